tl_timer_ctrl: RTL and testbench

//  Timing and sensor-conditioning controller for the highway/farmroad traffic-light FSM.
//  - Restarts its interval timer on the FSM's state-change strobe (sc).
//  - Returns the short (ts) and long (tl) timeout flags.
//  - Conditions the raw farmroad car sensor into c.
//  - Holds runtime-programmable interval limits, applied at state boundaries only.

---
 rtl/tl_timer_ctrl.sv | 115 +++++++++++
 tb/tb_tl_timer_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tl_timer_ctrl.sv
// Interval timer, runtime-programmable limits and car-sensor conditioning for the traffic-light FSM.
// Optional debounce of the car sensor: define CAR_DEBOUNCE_EN.
module tl_timer_ctrl #(
    parameter int CNT_W      = 16,
    parameter int TICK_DIV   = 1000,
    parameter int TS_DEFAULT = 5,
    parameter int TL_DEFAULT = 25,
    parameter int DB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sc,
    input  logic             car_raw,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             ts,
    output logic             tl,
    output logic             c,
    output logic [CNT_W-1:0] elapsed
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (TICK_DIV < 1 || DB_CYCLES < 1) begin : g_param_check
        $error("tl_timer_ctrl: TICK_DIV and DB_CYCLES must be >= 1");
    end

    function automatic logic [CNT_W-1:0] clamp_limit(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    localparam logic [CNT_W-1:0] TS_RST = clamp_limit(CNT_W'(TS_DEFAULT));
    localparam logic [CNT_W-1:0] TL_RST = clamp_limit(CNT_W'(TL_DEFAULT));

    logic [PW-1:0]    presc;
    logic             tick;
    logic [CNT_W-1:0] short_pend, long_pend;
    logic [CNT_W-1:0] short_act, long_act;
    logic [CNT_W-1:0] cfg_clamped;
    logic             car_s1, car_s;

    assign tick        = (presc == PW'(TICK_DIV - 1));
    assign cfg_clamped = clamp_limit(cfg_data);

    always_ff @(posedge clk) begin
        if (rst || sc) begin
            presc   <= '0;
            elapsed <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && elapsed != CNT_MAX) begin
                elapsed <= elapsed + CNT_W'(1);
            end
        end
    end

    // A write coinciding with sc bypasses straight into the active limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_pend <= TS_RST;
            long_pend  <= TL_RST;
            short_act  <= TS_RST;
            long_act   <= TL_RST;
        end else begin
            if (cfg_we && !cfg_sel) short_pend <= cfg_clamped;
            if (cfg_we &&  cfg_sel) long_pend  <= cfg_clamped;
            if (sc) begin
                short_act <= (cfg_we && !cfg_sel) ? cfg_clamped : short_pend;
                long_act  <= (cfg_we &&  cfg_sel) ? cfg_clamped : long_pend;
            end
        end
    end

    // Flags decode registered state only, so the FSM may derive sc from them.
    assign ts = (elapsed >= short_act);
    assign tl = (elapsed >= long_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            car_s1 <= 1'b0;
            car_s  <= 1'b0;
        end else begin
            car_s1 <= car_raw;
            car_s  <= car_s1;
        end
    end

`ifdef CAR_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES + 1);
    logic [DW-1:0] db_cnt;

    // Down-counter reloads on agreement; c flips at terminal count of a sustained mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= DW'(DB_CYCLES);
            c      <= 1'b0;
        end else if (car_s == c) begin
            db_cnt <= DW'(DB_CYCLES);
        end else if (db_cnt == '0) begin
            c      <= car_s;
            db_cnt <= DW'(DB_CYCLES);
        end else begin
            db_cnt <= db_cnt - DW'(1);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) c <= 1'b0;
        else     c <= car_s;
    end
`endif

endmodule

// File: tb/tb_tl_timer_ctrl.sv
// Directed bench for tl_timer_ctrl: vector table for timer/config, hand sequences for reset, car sensor, saturation.
module tb_tl_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst, sc, car_raw, cfg_we, cfg_sel;
    logic [7:0] cfg_data;
    logic       ts, tl, c;
    logic [7:0] elapsed;

    logic       rst2, sc2, car2, we2, sel2;
    logic [2:0] data2;
    logic       ts2, tl2, c2;
    logic [2:0] elapsed2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tl_timer_ctrl #(.CNT_W(8), .TICK_DIV(4), .TS_DEFAULT(2), .TL_DEFAULT(5), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sc(sc), .car_raw(car_raw), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .ts(ts), .tl(tl), .c(c), .elapsed(elapsed)
    );

    tl_timer_ctrl #(.CNT_W(3), .TICK_DIV(1), .TS_DEFAULT(7), .TL_DEFAULT(7), .DB_CYCLES(4)) dut_sat (
        .clk(clk), .rst(rst2), .sc(sc2), .car_raw(car2), .cfg_we(we2), .cfg_sel(sel2),
        .cfg_data(data2), .ts(ts2), .tl(tl2), .c(c2), .elapsed(elapsed2)
    );

    typedef struct {
        logic       sc;
        logic       we;
        logic       sel;
        logic [7:0] data;
        int         ncyc;
        int         exp_el;
        logic       exp_ts;
        logic       exp_tl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic w, logic sl, logic [7:0] d, int n,
                                int e, logic ets, logic etl);
        vec_t v;
        v.sc = s; v.we = w; v.sel = sl; v.data = d; v.ncyc = n;
        v.exp_el = e; v.exp_ts = ets; v.exp_tl = etl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_timer(input string name, input int e, input logic ets, input logic etl);
        chk({name, " elapsed"}, int'(elapsed), e);
        chk({name, " ts"}, int'(ts), int'(ets));
        chk({name, " tl"}, int'(tl), int'(etl));
    endtask

    initial begin
        rst = 1'b1; sc = 1'b0; car_raw = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
        rst2 = 1'b1; sc2 = 1'b0; car2 = 1'b0; we2 = 1'b0; sel2 = 1'b0; data2 = '0;

        // Edge numbers in comments: edge 1 = first edge with rst=0.
        vecs.push_back(mk(0, 0, 0, 8'd0,  3, 0,  0, 0)); // e3
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 1,  0, 0)); // e4 first tick
        vecs.push_back(mk(0, 0, 0, 8'd0,  3, 1,  0, 0)); // e7
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 2,  1, 0)); // e8 ts
        vecs.push_back(mk(0, 0, 0, 8'd0,  4, 3,  1, 0)); // e12
        vecs.push_back(mk(1, 0, 0, 8'd0,  1, 0,  0, 0)); // e13 restart
        vecs.push_back(mk(0, 0, 0, 8'd0,  7, 1,  0, 0)); // e20
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 2,  1, 0)); // e21 ts 8 after sc
        vecs.push_back(mk(0, 1, 1, 8'd10, 1, 2,  1, 0)); // e22 long pending=10
        vecs.push_back(mk(0, 0, 0, 8'd0, 10, 4,  1, 0)); // e32
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 5,  1, 1)); // e33 old long limit
        vecs.push_back(mk(1, 0, 0, 8'd0,  1, 0,  0, 0)); // e34
        vecs.push_back(mk(0, 0, 0, 8'd0, 39, 9,  1, 0)); // e73
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 10, 1, 1)); // e74 new long limit
        vecs.push_back(mk(1, 1, 0, 8'd0,  1, 0,  0, 0)); // e75 bypass, clamp 0->1
        vecs.push_back(mk(0, 0, 0, 8'd0,  3, 0,  0, 0)); // e78
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 1,  1, 0)); // e79 ts 4 after sc
        vecs.push_back(mk(0, 1, 1, 8'd3,  1, 1,  1, 0)); // e80
        vecs.push_back(mk(0, 1, 1, 8'd2,  1, 1,  1, 0)); // e81 last write wins
        vecs.push_back(mk(1, 0, 0, 8'd0,  1, 0,  0, 0)); // e82
        vecs.push_back(mk(0, 0, 0, 8'd0,  7, 1,  1, 0)); // e89
        vecs.push_back(mk(0, 0, 0, 8'd0,  1, 2,  1, 1)); // e90 long=2
        vecs.push_back(mk(1, 0, 0, 8'd0,  6, 0,  0, 0)); // e96 sc held
        vecs.push_back(mk(0, 0, 0, 8'd0,  4, 1,  1, 0)); // e100

        step(); step();
        chk_timer("reset", 0, 0, 0);
        chk("reset c", int'(c), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            sc = vecs[i].sc; cfg_we = vecs[i].we; cfg_sel = vecs[i].sel; cfg_data = vecs[i].data;
            repeat (vecs[i].ncyc) step();
            chk_timer($sformatf("vec%0d", i), vecs[i].exp_el, vecs[i].exp_ts, vecs[i].exp_tl);
        end
        sc = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;

        // Reset mid-interval must drop pending writes too.
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd9; step();
        cfg_sel = 1'b1; step();
        cfg_we = 1'b0; cfg_data = '0; rst = 1'b1; step();
        chk_timer("midrst", 0, 0, 0);
        rst = 1'b0;
        repeat (7) step();
        chk_timer("midrst e7", 1, 0, 0);
        step();
        chk_timer("midrst e8", 2, 1, 0);
        sc = 1'b1; step(); sc = 1'b0;
        repeat (8) step();
        chk_timer("pend discarded", 2, 1, 0);
        repeat (12) step();
        chk_timer("pend discarded long", 5, 1, 1);

        // Car sensor: 2-cycle pulse.
        car_raw = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k == 2) car_raw = 1'b0;
            step();
`ifdef CAR_DEBOUNCE_EN
            chk($sformatf("car pulse k%0d", k), int'(c), 0);
`else
            chk($sformatf("car pulse k%0d", k), int'(c), (k == 2 || k == 3) ? 1 : 0);
`endif
        end
        car_raw = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step();
`ifdef CAR_DEBOUNCE_EN
            chk($sformatf("car rise k%0d", k), int'(c), (k >= 6) ? 1 : 0);
`else
            chk($sformatf("car rise k%0d", k), int'(c), (k >= 2) ? 1 : 0);
`endif
        end
        car_raw = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            step();
`ifdef CAR_DEBOUNCE_EN
            chk($sformatf("car fall k%0d", k), int'(c), (k >= 6) ? 0 : 1);
`else
            chk($sformatf("car fall k%0d", k), int'(c), (k >= 2) ? 0 : 1);
`endif
        end

        // Saturation: 3-bit counter, tick every cycle, limits 7.
        rst2 = 1'b1; step(); step();
        chk("sat reset elapsed", int'(elapsed2), 0);
        rst2 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("sat elapsed k%0d", k), int'(elapsed2), (k < 7) ? k : 7);
            chk($sformatf("sat tl k%0d", k), int'(tl2), (k >= 7) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
